// File: rtl/bird_pkg.sv
// Shared bird/screen definitions: game state encoding and default screen
// geometry used by the motion engine, pipe generator and renderer.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        FALL = 2'd2,
        DEAD = 2'd3
    } bird_state_t;

    localparam int BIRD_X_POS  = 500;
    localparam int BIRD_Y_INIT = 380;
    localparam int BIRD_Y_MIN  = 0;
    localparam int BIRD_Y_MAX  = 700;

endpackage

// File: rtl/bird_motion_rise_pulse.sv
// Rising-edge detector. The history register resets to 1 so that a level
// already high when reset releases is not mistaken for a fresh edge.
module rise_pulse (
    input  logic clk,
    input  logic rstn,
    input  logic sig_i,
    output logic ev_o
);

    logic sig_q;

    // Remember the previous level of the input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign ev_o = sig_i & ~sig_q;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical-motion engine: flap impulse, gravity with terminal velocity,
// ceiling/floor clamping and the IDLE/FLY/FALL/DEAD game state.
module bird_motion
    import bird_pkg::*;
#(
    parameter int W          = 12,
    parameter int VW         = 8,
    parameter int X_POS      = BIRD_X_POS,
    parameter int Y_INIT     = BIRD_Y_INIT,
    parameter int Y_MIN      = BIRD_Y_MIN,
    parameter int Y_MAX      = BIRD_Y_MAX,
    parameter int GRAVITY    = 1,
    parameter int FLAP_SPEED = 8,
    parameter int VEL_MAX    = 12
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 tick,
    input  logic                 flap,
    input  logic                 crash,
    input  logic                 restart,
    output logic [W-1:0]         bird_x,
    output logic [W-1:0]         bird_y,
    output logic signed [VW-1:0] bird_vel,
    output logic [1:0]           state,
    output logic                 floor_hit,
    output logic                 ceil_hit
);

    // Position step is evaluated two bits wider than the coordinate so that
    // overshoot past either bound is visible before clamping.
    localparam int YW = W + 2;

    localparam logic [W-1:0]          Y_INIT_V = W'(Y_INIT);
    localparam logic [W-1:0]          Y_MIN_V  = W'(Y_MIN);
    localparam logic [W-1:0]          Y_MAX_V  = W'(Y_MAX);
    localparam logic signed [YW-1:0]  Y_MIN_S  = YW'(Y_MIN);
    localparam logic signed [YW-1:0]  Y_MAX_S  = YW'(Y_MAX);
    localparam logic signed [VW-1:0]  VEL_UP   = VW'(-FLAP_SPEED);
    localparam logic signed [VW-1:0]  VEL_TOP  = VW'(VEL_MAX);
    localparam logic signed [VW:0]    VEL_TOPX = (VW+1)'(VEL_MAX);
    localparam logic signed [VW:0]    GRAV_X   = (VW+1)'(GRAVITY);

    if (FLAP_SPEED >= 2 ** (VW - 1) || VEL_MAX >= 2 ** (VW - 1)) begin : g_bad_vel
        $error("bird_motion: FLAP_SPEED and VEL_MAX must fit in VW-1 bits");
    end
    if (!(Y_MIN < Y_INIT && Y_INIT < Y_MAX)) begin : g_bad_y
        $error("bird_motion: require Y_MIN < Y_INIT < Y_MAX");
    end
    if (Y_MAX >= 2 ** W || YW <= VW) begin : g_bad_w
        $error("bird_motion: W too narrow for the screen or velocity");
    end

    logic tick_ev;
    logic flap_ev;

    rise_pulse u_tick_edge (
        .clk   (clk),
        .rstn  (rstn),
        .sig_i (tick),
        .ev_o  (tick_ev)
    );

    rise_pulse u_flap_edge (
        .clk   (clk),
        .rstn  (rstn),
        .sig_i (flap),
        .ev_o  (flap_ev)
    );

    bird_state_t           state_q, state_d;
    logic [W-1:0]          y_q, y_d;
    logic signed [VW-1:0]  vel_q, vel_d;
    logic                  floor_q, floor_d;
    logic                  ceil_q, ceil_d;

    logic signed [YW-1:0]  y_step;
    logic signed [VW:0]    vel_inc;
    logic signed [VW-1:0]  vel_step;
    logic                  do_step;

    // Candidate position/velocity for one physics step, using the old velocity.
    always_comb begin
        y_step   = $signed({2'b00, y_q}) + $signed({{(YW - VW){vel_q[VW-1]}}, vel_q});
        vel_inc  = $signed({vel_q[VW-1], vel_q}) + GRAV_X;
        vel_step = (vel_inc > VEL_TOPX) ? VEL_TOP : vel_inc[VW-1:0];
    end

    // Next-state logic: restart > crash > flap > tick, then bound clamping.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        floor_d = 1'b0;
        ceil_d  = 1'b0;
        do_step = 1'b0;

        if (restart) begin
            state_d = IDLE;
            y_d     = Y_INIT_V;
            vel_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    y_d   = Y_INIT_V;
                    vel_d = '0;
                    if (flap_ev) begin
                        state_d = FLY;
                        vel_d   = VEL_UP;
                    end
                end
                FLY: begin
                    if (crash) begin
                        state_d = FALL;
                    end else if (flap_ev) begin
                        vel_d = VEL_UP;
                    end else if (tick_ev) begin
                        do_step = 1'b1;
                    end
                end
                FALL: begin
                    if (tick_ev) begin
                        do_step = 1'b1;
                    end
                end
                DEAD: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (do_step) begin
            if (y_step <= Y_MIN_S) begin
                y_d    = Y_MIN_V;
                vel_d  = '0;
                ceil_d = 1'b1;
            end else if (y_step >= Y_MAX_S) begin
                y_d     = Y_MAX_V;
                vel_d   = '0;
                floor_d = 1'b1;
                state_d = DEAD;
            end else begin
                y_d   = y_step[W-1:0];
                vel_d = vel_step;
            end
        end
    end

    // State, position, velocity and contact pulse registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            y_q     <= Y_INIT_V;
            vel_q   <= '0;
            floor_q <= 1'b0;
            ceil_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            floor_q <= floor_d;
            ceil_q  <= ceil_d;
        end
    end

    assign bird_x    = W'(X_POS);
    assign bird_y    = y_q;
    assign bird_vel  = vel_q;
    assign state     = state_q;
    assign floor_hit = floor_q;
    assign ceil_hit  = ceil_q;

endmodule

// File: tb/tb_bird_motion.sv
// Bench for bird_motion: directed scenarios followed by randomized input
// traffic, every cycle compared against a behavioural model of the game rules.
module tb_bird_motion;

    localparam int X_POS   = 500;
    localparam int Y_INIT  = 380;
    localparam int Y_MIN   = 0;
    localparam int Y_MAX   = 700;
    localparam int GRAV    = 1;
    localparam int FLAP_V  = 8;
    localparam int VMAX    = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, tick, flap, crash, restart;
    logic [11:0]       bird_x, bird_y;
    logic signed [7:0] bird_vel;
    logic [1:0]        state;
    logic              floor_hit, ceil_hit;

    bird_motion dut (
        .clk       (clk),
        .rstn      (rstn),
        .tick      (tick),
        .flap      (flap),
        .crash     (crash),
        .restart   (restart),
        .bird_x    (bird_x),
        .bird_y    (bird_y),
        .bird_vel  (bird_vel),
        .state     (state),
        .floor_hit (floor_hit),
        .ceil_hit  (ceil_hit)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model (0 idle, 1 fly, 2 fall, 3 dead)
    int m_y, m_vel, m_st, m_fh, m_ch, m_ptick, m_pflap;
    int f_cnt, c_cnt;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_y = Y_INIT; m_vel = 0; m_st = 0; m_fh = 0; m_ch = 0;
        m_ptick = 1; m_pflap = 1;
    endtask

    task automatic physics();
        int yn;
        int vn;
        yn = m_y + m_vel;
        vn = (m_vel + GRAV > VMAX) ? VMAX : m_vel + GRAV;
        if (yn <= Y_MIN) begin
            m_y = Y_MIN; m_vel = 0; m_ch = 1;
        end else if (yn >= Y_MAX) begin
            m_y = Y_MAX; m_vel = 0; m_fh = 1; m_st = 3;
        end else begin
            m_y = yn; m_vel = vn;
        end
    endtask

    task automatic model_step();
        bit tev;
        bit fev;
        if (!rstn) begin
            model_reset();
            return;
        end
        tev = (tick == 1'b1) && (m_ptick == 0);
        fev = (flap == 1'b1) && (m_pflap == 0);
        m_ptick = int'(tick);
        m_pflap = int'(flap);
        m_fh = 0;
        m_ch = 0;
        if (restart) begin
            m_st = 0; m_y = Y_INIT; m_vel = 0;
        end else begin
            case (m_st)
                0: if (fev) begin m_st = 1; m_vel = -FLAP_V; end
                1: begin
                    if (crash) m_st = 2;
                    else if (fev) m_vel = -FLAP_V;
                    else if (tev) physics();
                end
                2: if (tev) physics();
                default: ;
            endcase
        end
    endtask

    // One clock: drive on the falling edge, update model, check after rising edge.
    task automatic cyc(input logic t, input logic f, input logic c,
                       input logic r, input logic rn);
        @(negedge clk);
        tick = t; flap = f; crash = c; restart = r; rstn = rn;
        @(posedge clk);
        model_step();
        #1;
        if (floor_hit) f_cnt++;
        if (ceil_hit)  c_cnt++;
        chk("bird_x",    int'(bird_x),    X_POS);
        chk("bird_y",    int'(bird_y),    m_y);
        chk("bird_vel",  int'(bird_vel),  m_vel);
        chk("state",     int'(state),     m_st);
        chk("floor_hit", int'(floor_hit), m_fh);
        chk("ceil_hit",  int'(ceil_hit),  m_ch);
    endtask

    task automatic tick_once(input logic f);
        cyc(1'b0, f, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, f, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int y_before;
        int maxv;
        int guard;
        int fpct;

        rstn = 1'b0; tick = 1'b1; flap = 1'b1; crash = 1'b0; restart = 1'b0;
        model_reset();

        // 1: reset with tick and flap held high, no events after release
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_held_state", int'(state), 0);
        for (int i = 0; i < 5; i++) tick_once(1'b0);
        chk("t1_y", int'(bird_y), 380);
        chk("t1_vel", int'(bird_vel), 0);
        chk("t1_state", int'(state), 0);

        // 2: flap then two ticks
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_state", int'(state), 1);
        chk("t2_vel0", int'(bird_vel), -8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick_once(1'b0);
        chk("t2_y1", int'(bird_y), 372);
        chk("t2_v1", int'(bird_vel), -7);
        tick_once(1'b0);
        chk("t2_y2", int'(bird_y), 365);
        chk("t2_v2", int'(bird_vel), -6);

        // 3: flap held high with ticks, then flap and tick together
        for (int i = 0; i < 10; i++) cyc(logic'(i % 2), 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_y_held", int'(bird_y), 335);
        chk("t3_v_held", int'(bird_vel), -3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        y_before = int'(bird_y);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_same_vel", int'(bird_vel), -8);
        chk("t3_same_y", int'(bird_y), y_before);

        // 4: free fall to the floor
        f_cnt = 0; maxv = -100; guard = 0;
        while (m_st != 3 && guard < 60) begin
            tick_once(1'b0);
            if (int'(bird_vel) > maxv) maxv = int'(bird_vel);
            guard++;
        end
        chk("t4_vel_sat", maxv, 12);
        chk("t4_dead", int'(state), 3);
        chk("t4_y", int'(bird_y), 700);
        for (int i = 0; i < 4; i++) tick_once(1'b1);
        tick_once(1'b0);
        chk("t4_floor_cnt", f_cnt, 1);
        chk("t4_dead_hold_y", int'(bird_y), 700);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_restart_state", int'(state), 0);
        chk("t4_restart_y", int'(bird_y), 380);

        // 5: flap every tick up to the ceiling
        c_cnt = 0; guard = 0;
        while (m_ch == 0 && guard < 80) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("t5_ceil_y", int'(bird_y), 0);
        chk("t5_ceil_vel", int'(bird_vel), 0);
        chk("t5_ceil_state", int'(state), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_ceil_cnt", c_cnt, 1);

        // 6: crash with vel=-3, ignored flaps, fall to floor; crash+restart
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) tick_once(1'b0);
        chk("t6_pre_vel", int'(bird_vel), -3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t6_fall", int'(state), 2);
        chk("t6_fall_vel", int'(bird_vel), -3);
        guard = 0;
        while (m_st != 3 && guard < 60) begin
            tick_once(logic'(guard % 2));
            guard++;
        end
        chk("t6_dead", int'(state), 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t6_crash_restart", int'(state), 0);

        // Randomized traffic with varying flap density
        for (int seg = 0; seg < 12; seg++) begin
            fpct = (seg % 3 == 0) ? 5 : ((seg % 3 == 1) ? 25 : 60);
            for (int i = 0; i < 200; i++) begin
                cyc(logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 99) < fpct),
                    logic'($urandom_range(0, 79) == 0),
                    logic'($urandom_range(0, 199) == 0),
                    logic'($urandom_range(0, 499) != 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
Parametrised bird vertical-motion engine with signed velocity, gravity, flap impulse, terminal velocity and screen-bound clamping. It sits between the input/debounce logic (flap), the frame-tick source (tick) and the pipe collision checker (crash). It feeds bird_x/bird_y to the VGA renderer and the collision checker, and reports game state to the top-level controller.

Parameters:
W, 12, coordinate width (bird_x, bird_y)
VW, 8, signed velocity width (two's complement)
X_POS, 500, fixed horizontal position
Y_INIT, 380, vertical position in IDLE and after reset/restart
Y_MIN, 0, ceiling coordinate
Y_MAX, 700, floor coordinate
GRAVITY, 1, velocity increment per tick
FLAP_SPEED, 8, magnitude of upward velocity set by a flap
VEL_MAX, 12, terminal (maximum downward) velocity

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
tick  in  1  frame tick level; rising edge = one physics step
flap  in  1  flap request level; rising edge = one flap event
crash  in  1  collision with pipe, sampled every cycle
restart  in  1  return to IDLE, sampled every cycle
bird_x  out  W  always X_POS
bird_y  out  W  current vertical position
bird_vel  out  VW  signed current velocity (positive = downward)
state  out  2  IDLE=0, FLY=1, FALL=2, DEAD=3
floor_hit  out  1  one-cycle pulse on floor contact
ceil_hit  out  1  one-cycle pulse on ceiling clamp

Behaviour:
- Reset (rstn low at a clk edge) applies the following values:
  - bird_y=Y_INIT, bird_vel=0, state=IDLE, floor_hit=0, ceil_hit=0.
  - Edge-detect history registers for tick and flap reset to 1, so a level held high through reset produces no event.
- tick_ev = tick & ~tick_d; flap_ev = flap & ~flap_d. Each is one cycle wide. All outputs are registered; an event affects outputs on the next edge.
- Priority within one cycle: restart > crash > flap_ev > tick_ev.
- restart, any state -> IDLE with reset values of y/vel; pulses are cleared.
- IDLE:
  - bird_y=Y_INIT, vel=0; ticks are ignored.
  - flap_ev -> FLY, vel=-FLAP_SPEED, y unchanged.
  - crash is ignored.
- FLY:
  - flap_ev -> vel=-FLAP_SPEED, y unchanged (a tick in the same cycle is dropped).
  - tick_ev -> y_n = y + vel (old vel); vel_n = min(vel+GRAVITY, VEL_MAX).
  - crash -> FALL; vel is kept.
- Step arithmetic: y_n is computed sign-extended at W+2 bits.
  - If y_n <= Y_MIN: bird_y=Y_MIN, vel=0, ceil_hit=1 for one cycle.
  - If y_n >= Y_MAX: bird_y=Y_MAX, vel=0, floor_hit=1 for one cycle, state -> DEAD.
  - Otherwise bird_y=y_n.
- FALL:
  - Same tick physics as FLY; flap_ev and crash are ignored.
  - Floor contact -> DEAD with floor_hit.
- DEAD: all inputs except restart are ignored; y and vel hold.
- Velocity never exceeds VEL_MAX downward. The upward extreme is -FLAP_SPEED. Elaboration-time asserts: FLAP_SPEED and VEL_MAX fit in VW-1 bits, and Y_MIN < Y_INIT < Y_MAX.
- rstn low mid-flight returns to the reset values on that edge.

Decomposition:
- Package bird_pkg holds:
  - state enum (IDLE, FLY, FALL, DEAD);
  - default screen constants (Y_MIN, Y_MAX, Y_INIT, X_POS), shared with the pipe generator and the renderer.
- One sub-module, rise_pulse: a rising-edge detector with synchronous active-low reset and a reset value of 1. It is instantiated twice (tick, flap).

Test Plan:
1. Reset, then 5 ticks with no flap -> bird_y=380, bird_vel=0, state=IDLE throughout; tick held high across reset produces no event.
2. Flap pulse then 2 ticks -> state=FLY, vel=-8; after tick 1: y=372, vel=-7; after tick 2: y=365, vel=-6.
3. flap held high 10 cycles with ticks between -> exactly one flap event. Flap and tick in the same cycle -> vel=-8, y unchanged.
4. FLY with no flaps for 30 ticks -> vel climbs by 1 per tick and saturates at 12. Eventually y_n >= 700: bird_y=700, floor_hit high exactly one cycle, state=DEAD; further ticks and flaps change nothing; restart -> IDLE, y=380, vel=0.
5. Flap every tick from y=380 -> y decreases by 8 per step until y_n <= 0: bird_y=0, vel=0, ceil_hit one cycle, state stays FLY.
6. crash asserted in FLY with vel=-3 -> FALL; subsequent flaps ignored; bird rises, then falls to 700 -> DEAD. crash and restart in the same cycle -> IDLE.
